// File: rtl/bcd_counter_segdis_n.sv
// N-digit BCD up/down counter with prescaled count rate, synchronous load, carry/borrow
// pulse, and a scanned 7-segment display driver with optional leading-zero blanking.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   en_i        count enable, sampled on prescaler ticks
//   up_dn_i     1 = count up, 0 = count down
//   load_i      synchronous load strobe (wins over a coincident tick)
//   load_val_i  BCD load value, digit 0 in [3:0]; nibbles above 9 saturate to 9
//   blank_lz_i  1 = blank leading zero digits (digit 0 never blanked)
//   count_o     current BCD value, digit 0 in [3:0]
//   carry_o     one-cycle pulse when the count wraps in either direction
//   seg_com_o   digit strobes, bit i = digit i
//   seg_data_o  segments {a,b,c,d,e,f,g,dp}, bit 7 = a
module bcd_counter_segdis_n #(
   parameter int unsigned DIGITS         = 8,
   parameter int unsigned CNT_DIV        = 1000000,
   parameter int unsigned SCAN_DIV       = 10000,
   parameter bit          COM_ACTIVE_LOW = 1'b1,
   parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  up_dn_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   load_val_i,
   input  logic                  blank_lz_i,
   output logic [4*DIGITS-1:0]   count_o,
   output logic                  carry_o,
   output logic [7:0]            seg_com_o,
   output logic [7:0]            seg_data_o
);

   localparam int unsigned CntW  = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;
   localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0]  CntMax  = CntW'(CNT_DIV - 1);
   localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);
   localparam logic [2:0]       IdxMax  = 3'(DIGITS - 1);
   localparam logic [7:0]       ComOff  = COM_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [7:0]       SegOff  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   logic [CntW-1:0]     presc_q, presc_d;
   logic [ScanW-1:0]    scan_q, scan_d;
   logic [2:0]          idx_q, idx_d;
   logic [4*DIGITS-1:0] count_q, count_d;
   logic                carry_q, carry_d;
   logic [7:0]          seg_com_q, seg_com_d;
   logic [7:0]          seg_data_q, seg_data_d;

   logic                tick;
   logic [4*DIGITS-1:0] step_val;
   logic                wrap;

   // Free-running dividers for the count rate and the display scan
   always_comb begin
      tick    = (presc_q == CntMax);
      presc_d = tick ? '0 : presc_q + CntW'(1);
      idx_d   = idx_q;
      if (scan_q == ScanMax) begin
         scan_d = '0;
         idx_d  = (idx_q == IdxMax) ? 3'd0 : idx_q + 3'd1;
      end else begin
         scan_d = scan_q + ScanW'(1);
      end
   end

   // Ripple step: wrap stays set only while every digit so far rolled over
   always_comb begin
      step_val = count_q;
      wrap     = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (wrap) begin
            if (up_dn_i) begin
               if (count_q[4*i +: 4] == 4'd9) begin
                  step_val[4*i +: 4] = 4'd0;
               end else begin
                  step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                  wrap               = 1'b0;
               end
            end else begin
               if (count_q[4*i +: 4] == 4'd0) begin
                  step_val[4*i +: 4] = 4'd9;
               end else begin
                  step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                  wrap               = 1'b0;
               end
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      carry_d = 1'b0;
      if (load_i) begin
         for (int i = 0; i < DIGITS; i++) begin
            count_d[4*i +: 4] = (load_val_i[4*i +: 4] > 4'd9) ? 4'd9 : load_val_i[4*i +: 4];
         end
      end else if (tick && en_i) begin
         count_d = step_val;
         carry_d = wrap;
      end
   end

   // Display path: digits above DIGITS read as zero so the blanking chain is uniform
   logic [31:0] count_ext;
   logic [3:0]  digit [8];
   logic [7:0]  zero_from;
   logic [3:0]  cur_digit;
   logic        blank;
   logic [7:0]  seg_raw;
   logic [7:0]  com_onehot;

   always_comb begin
      count_ext = 32'(count_q);
      for (int i = 0; i < 8; i++) begin
         digit[i] = count_ext[4*i +: 4];
      end
      zero_from[7] = (digit[7] == 4'd0);
      for (int i = 6; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] && (digit[i] == 4'd0);
      end
      cur_digit = digit[idx_q];
      blank     = blank_lz_i && (idx_q != 3'd0) && zero_from[idx_q];
      case (cur_digit)
         4'd0:    seg_raw = 8'hFC;
         4'd1:    seg_raw = 8'h60;
         4'd2:    seg_raw = 8'hDA;
         4'd3:    seg_raw = 8'hF2;
         4'd4:    seg_raw = 8'h66;
         4'd5:    seg_raw = 8'hB6;
         4'd6:    seg_raw = 8'hBE;
         4'd7:    seg_raw = 8'hE0;
         4'd8:    seg_raw = 8'hFE;
         4'd9:    seg_raw = 8'hF6;
         default: seg_raw = 8'h00;
      endcase
      if (blank) begin
         seg_raw = 8'h00;
      end
      seg_data_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      com_onehot = 8'b1 << idx_q;
      seg_com_d  = COM_ACTIVE_LOW ? ~com_onehot : com_onehot;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         presc_q    <= '0;
         scan_q     <= '0;
         idx_q      <= 3'd0;
         count_q    <= '0;
         carry_q    <= 1'b0;
         seg_com_q  <= ComOff;
         seg_data_q <= SegOff;
      end else begin
         presc_q    <= presc_d;
         scan_q     <= scan_d;
         idx_q      <= idx_d;
         count_q    <= count_d;
         carry_q    <= carry_d;
         seg_com_q  <= seg_com_d;
         seg_data_q <= seg_data_d;
      end
   end

   assign count_o    = count_q;
   assign carry_o    = carry_q;
   assign seg_com_o  = seg_com_q;
   assign seg_data_o = seg_data_q;

endmodule
